// File: rtl/part_cmd_engine_pkg.sv
// Shared definitions for the part tester command engine: host command
// bytes, ASCII reply bytes, the engine state encoding and a small helper.
package part_cmd_pkg;

    localparam logic [7:0] CMD_RESET       = 8'h72; // 'r'
    localparam logic [7:0] CMD_SET_STATE   = 8'h73; // 's'
    localparam logic [7:0] CMD_GET_STATE   = 8'h67; // 'g'
    localparam logic [7:0] CMD_SET_INPUTS  = 8'h69; // 'i'
    localparam logic [7:0] CMD_GET_OUTPUTS = 8'h6F; // 'o'
    localparam logic [7:0] CMD_EXECUTE     = 8'h65; // 'e'
    localparam logic [7:0] CMD_FREE_RUN    = 8'h66; // 'f'
    localparam logic [7:0] CMD_PAUSE       = 8'h70; // 'p'

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_1   = 8'h31;
    localparam logic [7:0] ASCII_ACK = 8'h6B; // 'k'

    // IDLE is fixed at 5 so the debug LEDs read the same on every build.
    typedef enum logic [3:0] {
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_GET_BIT = 4'd3,
        ST_SHIFT   = 4'd4,
        ST_IDLE    = 4'd5,
        ST_SEND    = 4'd6,
        ST_WAIT_TX = 4'd7,
        ST_PULSE   = 4'd8,
        ST_RUN     = 4'd9,
        ST_RESET   = 4'd10,
        ST_ACK     = 4'd11
    } state_t;

    function automatic logic [7:0] ascii_bit(input logic b);
        return b ? ASCII_1 : ASCII_0;
    endfunction

endpackage

// File: rtl/part_cmd_engine_if.sv
// Byte-level link between the command engine and the UART pair.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data, with no
// backpressure (bytes the engine cannot take are lost). On the transmit
// side the engine raises tx_start with tx_data valid and holds both until
// tx_ready falls (transmitter accepted the byte), then drops tx_start and
// waits for tx_ready to rise again before offering the next byte.
interface part_cmd_engine_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_start, tx_data
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_start, tx_data
    );
endinterface

// File: rtl/part_cmd_engine_clk_gen.sv
// part_clk_gen: generates `count` part clock pulses (1 cycle high, 1 cycle
// low) or, with free_run, a continuous clock that halts in its low phase
// once stop has been seen. done is high during the final low cycle.
module part_clk_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        free_run,
    input  logic        stop,
    input  logic [15:0] count,
    output logic        part_clk,
    output logic        done
);

    logic        active_q;
    logic        run_q;
    logic        stop_q;
    logic [15:0] remain_q;

    // A stop arriving in the high phase is remembered so the clock can
    // finish that pulse and halt low on the following cycle.
    assign done = active_q && !part_clk &&
                  (run_q ? (stop || stop_q) : (remain_q == 16'd0));

    // Pulse sequencer: high phase, low phase, repeat until finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            run_q    <= 1'b0;
            stop_q   <= 1'b0;
            remain_q <= 16'd0;
            part_clk <= 1'b0;
        end else if (!active_q) begin
            stop_q <= 1'b0;
            if (start && (free_run || count != 16'd0)) begin
                active_q <= 1'b1;
                run_q    <= free_run;
                remain_q <= count;
                part_clk <= 1'b1;
            end
        end else if (part_clk) begin
            part_clk <= 1'b0;
            if (!run_q) remain_q <= remain_q - 16'd1;
            if (stop) stop_q <= 1'b1;
        end else if (done) begin
            active_q <= 1'b0;
        end else begin
            part_clk <= 1'b1;
        end
    end

endmodule

// File: rtl/part_cmd_engine.sv
// part_cmd_engine: decodes the single-letter host protocol arriving from
// the UART and drives the part under test (scan chain, primary inputs and
// outputs, part clock and reset). Replies go back one byte at a time.
// Build option: define PART_CMD_ACK_EN to send 'k' after every command.
module part_cmd_engine
    import part_cmd_pkg::*;
#(
    parameter int NPIS       = 14,
    parameter int NPOS       = 11,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    part_cmd_engine_if.master bus,
    output logic             part_clk,
    output logic             part_rstn,
    output logic             scan_en,
    output logic             test_mode,
    output logic             scan_in,
    input  logic             scan_out,
    output logic [NPIS-1:0]  pis_o,
    input  logic [NPOS-1:0]  pos_i,
    output logic             busy,
    output logic [3:0]       state_o
);

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     idx_q, idx_d;
    logic            scan_en_q, scan_en_d;
    logic            test_mode_q, test_mode_d;
    logic            scan_in_q, scan_in_d;
    logic            part_rstn_q, part_rstn_d;
    logic [NPIS-1:0] pis_q, pis_d;
    logic [NPOS-1:0] pos_q, pos_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            gen_start, gen_free, gen_stop, gen_done;
    logic [15:0]     gen_count;
    logic            cmd_done;

    logic [15:0]     len_n;
    logic [15:0]     idx_inc;
    logic            last;
    logic            rx_bit;
    logic [NPIS-1:0] pis_mask;
    logic            pos_bit_cur, pos_bit_nxt;

    // Out-of-range indices give an all-zero mask / bit, so extra 'i' bytes
    // are dropped and extra 'o' indices read back as '0'.
    assign len_n       = {len_q[15:8], bus.rx_data};
    assign idx_inc     = idx_q + 16'd1;
    assign last        = (idx_q == len_q - 16'd1);
    assign rx_bit      = (bus.rx_data == ASCII_1);
    assign pis_mask    = NPIS'(1) << idx_q;
    assign pos_bit_cur = |(pos_q & (NPOS'(1) << idx_q));
    assign pos_bit_nxt = |(pos_q & (NPOS'(1) << idx_inc));

    part_clk_gen u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (gen_start),
        .free_run (gen_free),
        .stop     (gen_stop),
        .count    (gen_count),
        .part_clk (part_clk),
        .done     (gen_done)
    );

    // Next-state and next-register logic for the command FSM.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        scan_en_d   = scan_en_q;
        test_mode_d = test_mode_q;
        scan_in_d   = scan_in_q;
        part_rstn_d = part_rstn_q;
        pis_d       = pis_q;
        pos_d       = pos_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        gen_start   = 1'b0;
        gen_free    = 1'b0;
        gen_stop    = 1'b0;
        gen_count   = len_q;
        cmd_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_SET_STATE, CMD_GET_STATE, CMD_SET_INPUTS,
                        CMD_GET_OUTPUTS, CMD_EXECUTE: begin
                            cmd_d   = bus.rx_data;
                            idx_d   = 16'd0;
                            state_d = ST_LEN_HI;
                            if (bus.rx_data == CMD_GET_OUTPUTS) pos_d = pos_i;
                        end
                        CMD_FREE_RUN: begin
                            cmd_d     = bus.rx_data;
                            gen_start = 1'b1;
                            gen_free  = 1'b1;
                            state_d   = ST_RUN;
                        end
                        CMD_RESET: begin
                            cmd_d       = bus.rx_data;
                            gen_start   = 1'b1;
                            gen_count   = 16'(RST_CYCLES);
                            part_rstn_d = 1'b0;
                            state_d     = ST_RESET;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d[15:8] = bus.rx_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d = len_n;
                    if (len_n == 16'd0) begin
                        cmd_done = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_SET_STATE, CMD_SET_INPUTS: state_d = ST_GET_BIT;
                            CMD_GET_STATE: begin
                                scan_en_d   = 1'b1;
                                test_mode_d = 1'b1;
                                tx_data_d   = ascii_bit(scan_out);
                                tx_start_d  = 1'b1;
                                state_d     = ST_SEND;
                            end
                            CMD_GET_OUTPUTS: begin
                                tx_data_d  = ascii_bit(pos_bit_cur);
                                tx_start_d = 1'b1;
                                state_d    = ST_SEND;
                            end
                            CMD_EXECUTE: begin
                                gen_start = 1'b1;
                                gen_count = len_n;
                                state_d   = ST_PULSE;
                            end
                            default: cmd_done = 1'b1;
                        endcase
                    end
                end
            end
            ST_GET_BIT: begin
                if (bus.rx_valid) begin
                    if (cmd_q == CMD_SET_STATE) begin
                        scan_in_d   = rx_bit;
                        scan_en_d   = 1'b1;
                        test_mode_d = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        pis_d = rx_bit ? (pis_q | pis_mask) : (pis_q & ~pis_mask);
                        idx_d = idx_inc;
                        if (last) cmd_done = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // scan_in settled last edge; the rising part_clk comes next.
                gen_start = 1'b1;
                gen_count = 16'd1;
                state_d   = ST_PULSE;
            end
            ST_PULSE: begin
                if (gen_done) begin
                    if (cmd_q == CMD_EXECUTE || last) begin
                        cmd_done = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        if (cmd_q == CMD_GET_STATE) begin
                            tx_data_d  = ascii_bit(scan_out);
                            tx_start_d = 1'b1;
                            state_d    = ST_SEND;
                        end else begin
                            state_d = ST_GET_BIT;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (!bus.tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (bus.tx_ready) begin
                    if (cmd_q == CMD_GET_STATE) begin
                        state_d = ST_SHIFT;
                    end else if (last) begin
                        cmd_done = 1'b1;
                    end else begin
                        idx_d      = idx_inc;
                        tx_data_d  = ascii_bit(pos_bit_nxt);
                        tx_start_d = 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_RUN: begin
                gen_stop = bus.rx_valid && (bus.rx_data == CMD_PAUSE);
                if (gen_done) cmd_done = 1'b1;
            end
            ST_RESET: begin
                if (gen_done) begin
                    part_rstn_d = 1'b1;
                    cmd_done    = 1'b1;
                end
            end
`ifdef PART_CMD_ACK_EN
            ST_ACK: begin
                if (tx_start_q) begin
                    if (!bus.tx_ready) tx_start_d = 1'b0;
                end else if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (cmd_done) begin
            scan_en_d   = 1'b0;
            test_mode_d = 1'b0;
            scan_in_d   = 1'b0;
`ifdef PART_CMD_ACK_EN
            tx_data_d   = ASCII_ACK;
            tx_start_d  = 1'b1;
            state_d     = ST_ACK;
`else
            state_d     = ST_IDLE;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and pin registers; reset aborts any command in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= 8'd0;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            scan_en_q   <= 1'b0;
            test_mode_q <= 1'b0;
            scan_in_q   <= 1'b0;
            part_rstn_q <= 1'b1;
            pis_q       <= '0;
            pos_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            scan_en_q   <= scan_en_d;
            test_mode_q <= test_mode_d;
            scan_in_q   <= scan_in_d;
            part_rstn_q <= part_rstn_d;
            pis_q       <= pis_d;
            pos_q       <= pos_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign scan_en      = scan_en_q;
    assign test_mode    = test_mode_q;
    assign scan_in      = scan_in_q;
    assign part_rstn    = part_rstn_q;
    assign pis_o        = pis_q;
    assign busy         = (state_q != ST_IDLE);
    assign state_o      = state_q;

endmodule
